// File: rtl/vblank_arbiter.sv
// Round-robin arbiter for the frame-buffer/sprite-RAM write port. Grants are
// issued only inside vertical blank, and each requester is served at most once per frame.
module vblank_arbiter #(
    parameter int N_REQ           = 4,
    parameter int LAST_GRANT_LINE = 624,
    localparam int ID_W           = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             v_blank,
    input  logic [10:0]      v_cnt,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             frame_start,
    output logic             abort
);

    typedef enum logic [1:0] {
        WAIT_BLANK,
        ARBITRATE,
        GRANTED,
        CLOSED
    } state_t;

    localparam logic [10:0]      LAST_LINE = 11'(LAST_GRANT_LINE);
    localparam logic [ID_W-1:0]  LAST_IDX  = ID_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

    state_t           state;
    logic             v_blank_q;
    logic [N_REQ-1:0] served;
    logic [ID_W-1:0]  rr_ptr;

    logic [N_REQ-1:0] pend;
    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;
    logic [ID_W-1:0]  scan_idx;

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    assign pend = req & ~served;

    // Scan pending requests starting at rr_ptr and wrapping at N_REQ-1.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        scan_idx   = rr_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_found && pend[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
            scan_idx = next_idx(scan_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_BLANK;
            v_blank_q   <= 1'b1;
            served      <= '0;
            rr_ptr      <= '0;
            gnt         <= '0;
            gnt_id      <= '0;
            gnt_valid   <= 1'b0;
            frame_start <= 1'b0;
            abort       <= 1'b0;
        end else begin
            v_blank_q   <= v_blank;
            frame_start <= 1'b0;
            abort       <= 1'b0;
            case (state)
                WAIT_BLANK: begin
                    if (v_blank && !v_blank_q) begin
                        frame_start <= 1'b1;
                        served      <= '0;
                        state       <= ARBITRATE;
                    end
                end
                ARBITRATE: begin
                    if (!v_blank) begin
                        state <= WAIT_BLANK;
                    end else if (v_cnt > LAST_LINE) begin
                        state <= CLOSED;
                    end else if (pick_found) begin
                        gnt       <= ONE_HOT0 << pick_idx;
                        gnt_id    <= pick_idx;
                        gnt_valid <= 1'b1;
                        state     <= GRANTED;
                    end
                end
                GRANTED: begin
                    // A release wins over the end of blank, so no abort then.
                    if (done[gnt_id] || !req[gnt_id]) begin
                        served[gnt_id] <= 1'b1;
                        rr_ptr         <= next_idx(gnt_id);
                        gnt            <= '0;
                        gnt_valid      <= 1'b0;
                        state          <= ARBITRATE;
                    end else if (!v_blank) begin
                        abort     <= 1'b1;
                        rr_ptr    <= next_idx(gnt_id);
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        state     <= WAIT_BLANK;
                    end
                end
                CLOSED: begin
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                    if (!v_blank) begin
                        state <= WAIT_BLANK;
                    end
                end
                default: state <= WAIT_BLANK;
            endcase
        end
    end

endmodule

// File: tb/tb_vblank_arbiter.sv
// Scoreboard bench for vblank_arbiter: each frame pushes its expected frame_start,
// grant and abort events; a negedge monitor pops and compares them as they appear.
module tb_vblank_arbiter;

    localparam int N_REQ     = 4;
    localparam int BLANK_LEN = 24;
    localparam int EV_FRAME  = 0;
    localparam int EV_GRANT  = 1;
    localparam int EV_ABORT  = 2;

    typedef struct {
        int kind;
        int id;
        int delta;
    } ev_t;

    logic             clk;
    logic             rst_n;
    logic             v_blank;
    logic [10:0]      v_cnt;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gnt;
    logic [1:0]       gnt_id;
    logic             gnt_valid;
    logic             frame_start;
    logic             abort;

    ev_t exp_q[$];
    int  n_compared   = 0;
    int  n_mismatched = 0;
    int  cyc          = 0;
    int  fs_cyc       = 0;
    logic prev_valid  = 1'b0;

    vblank_arbiter #(
        .N_REQ(N_REQ),
        .LAST_GRANT_LINE(624)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .v_blank(v_blank),
        .v_cnt(v_cnt),
        .req(req),
        .done(done),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .gnt_valid(gnt_valid),
        .frame_start(frame_start),
        .abort(abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input int id, input int delta);
        ev_t e;
        e.kind  = kind;
        e.id    = id;
        e.delta = delta;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic score_event(input int kind, input int id, input int delta);
        ev_t e;
        n_compared++;
        if (exp_q.size() == 0) begin
            n_mismatched++;
            $display("[TB] FAIL unexpected_event: got kind=%0d id=%0d delta=%0d, expected none",
                     kind, id, delta);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.id != id || e.delta != delta) begin
                n_mismatched++;
                $display("[TB] FAIL event: got kind=%0d id=%0d delta=%0d, expected kind=%0d id=%0d delta=%0d",
                         kind, id, delta, e.kind, e.id, e.delta);
            end
        end
    endtask

    // Event delta is measured in clocks from the frame_start pulse of the same frame.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_start) begin
                fs_cyc = cyc;
                score_event(EV_FRAME, int'(gnt), 0);
            end
            if (gnt_valid && !prev_valid) begin
                score_event(EV_GRANT,
                            (gnt == (4'b0001 << gnt_id)) ? int'(gnt_id) : 100 + int'(gnt),
                            cyc - fs_cyc);
            end
            if (abort) begin
                score_event(EV_ABORT, int'(gnt) + 16 * int'(gnt_valid), cyc - fs_cyc);
            end
        end
        prev_valid = gnt_valid;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    // hold[i]: 0 = keep grant; bit7 clear = pulse done after N owned clocks;
    // bit7 set = drop req after N owned clocks.
    task automatic applyStimulus(input logic [10:0] line, input logic [3:0] req_mask,
                                 input logic [3:0][7:0] hold, input int extra_cyc,
                                 input logic [3:0] extra_req, input logic [3:0] extra_done);
        int own;
        own     = 0;
        v_blank = 1'b0;
        req     = '0;
        done    = '0;
        step(4);
        v_cnt   = line;
        v_blank = 1'b1;
        req     = req_mask;
        for (int k = 1; k <= BLANK_LEN; k++) begin
            step(1);
            done = '0;
            if (gnt_valid) begin
                own++;
                if (hold[gnt_id][6:0] != 7'd0 && own == int'(hold[gnt_id][6:0])) begin
                    if (hold[gnt_id][7]) req[gnt_id] = 1'b0;
                    else                 done[gnt_id] = 1'b1;
                end
            end else begin
                own = 0;
            end
            if (k == extra_cyc) begin
                req  = req | extra_req;
                done = done | extra_done;
            end
            if (k == BLANK_LEN) v_blank = 1'b0;
        end
        step(1);
        req  = '0;
        done = '0;
        step(2);
    endtask

    initial begin
        ev_t e;
        rst_n   = 1'b0;
        v_blank = 1'b1;
        v_cnt   = 11'd600;
        req     = 4'b0001;
        done    = '0;
        #12;
        checkOutput("rst_gnt", int'(gnt), 0);
        checkOutput("rst_gnt_id", int'(gnt_id), 0);
        checkOutput("rst_gnt_valid", int'(gnt_valid), 0);
        checkOutput("rst_frame_start", int'(frame_start), 0);
        checkOutput("rst_abort", int'(abort), 0);
        #1 rst_n = 1'b1;
        step(8);
        checkOutput("midblank_gnt_valid", int'(gnt_valid), 0);
        checkOutput("midblank_gnt", int'(gnt), 0);

        // Reset inside blank: first grant only after the next rising edge.
        push_ev(EV_FRAME, 0, 0);
        push_ev(EV_GRANT, 0, 1);
        applyStimulus(11'd600, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, 0, 4'b0, 4'b0);

        do_reset();
        for (int f = 0; f < 2; f++) begin
            push_ev(EV_FRAME, 0, 0);
            push_ev(EV_GRANT, 0, 1);
            push_ev(EV_GRANT, 1, 5);
            push_ev(EV_GRANT, 2, 9);
            push_ev(EV_GRANT, 3, 13);
            applyStimulus(11'd600, 4'b1111, {8'd3, 8'd3, 8'd3, 8'd3}, 0, 4'b0, 4'b0);
        end

        // Owner 1 drops req, re-requests later in the frame and must not be regranted.
        push_ev(EV_FRAME, 0, 0);
        push_ev(EV_GRANT, 1, 1);
        push_ev(EV_GRANT, 2, 4);
        applyStimulus(11'd600, 4'b0110, {8'd0, 8'd3, 8'h82, 8'd0}, 5, 4'b0010, 4'b0);

        push_ev(EV_FRAME, 0, 0);
        push_ev(EV_GRANT, 3, 1);
        push_ev(EV_GRANT, 2, 5);
        push_ev(EV_ABORT, 0, BLANK_LEN);
        applyStimulus(11'd600, 4'b1100, {8'd3, 8'd0, 8'd0, 8'd0}, 0, 4'b0, 4'b0);

        push_ev(EV_FRAME, 0, 0);
        push_ev(EV_GRANT, 3, 1);
        push_ev(EV_GRANT, 0, 5);
        push_ev(EV_GRANT, 1, 9);
        push_ev(EV_GRANT, 2, 13);
        applyStimulus(11'd600, 4'b1111, {8'd3, 8'd3, 8'd3, 8'd3}, 0, 4'b0, 4'b0);

        push_ev(EV_FRAME, 0, 0);
        applyStimulus(11'd625, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, 0, 4'b0, 4'b0);

        push_ev(EV_FRAME, 0, 0);
        push_ev(EV_GRANT, 0, 1);
        applyStimulus(11'd624, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, 0, 4'b0, 4'b0);

        // A done from non-owner 2 must not release owner 0.
        push_ev(EV_FRAME, 0, 0);
        push_ev(EV_GRANT, 0, 1);
        push_ev(EV_ABORT, 0, BLANK_LEN);
        applyStimulus(11'd600, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd0}, 6, 4'b0, 4'b0100);

        // done lands in the same cycle as the v_blank fall: a release, not an abort.
        push_ev(EV_FRAME, 0, 0);
        push_ev(EV_GRANT, 0, 1);
        applyStimulus(11'd600, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd23}, 0, 4'b0, 4'b0);

        step(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL missing_event: got none, expected kind=%0d id=%0d delta=%0d",
                     e.kind, e.id, e.delta);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
